// File: rtl/addr_gen.sv
// Operand-fetch and effective-address sequencer. It fetches operand and pointer
// bytes over a byte-wide bus and forms the effective address for the ALU/LSU path.
module addr_gen #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 16,
    parameter bit          ZP_WRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] idx_x,
    input  logic [DATA_W-1:0] idx_y,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] d_in,
    output logic [ADDR_W-1:0] addr,
    output logic              pc_inc,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ea,
    output logic              page_cross
);

    localparam int unsigned HI_W  = ADDR_W - DATA_W;
    localparam int unsigned SUM_W = DATA_W + 1;

    localparam logic [2:0] M_ZPX  = 3'b000;
    localparam logic [2:0] M_ZP   = 3'b001;
    localparam logic [2:0] M_IMM  = 3'b010;
    localparam logic [2:0] M_ABS  = 3'b011;
    localparam logic [2:0] M_ZPY  = 3'b100;
    localparam logic [2:0] M_ABSX = 3'b101;
    localparam logic [2:0] M_ABSY = 3'b110;
    localparam logic [2:0] M_INDY = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        INDEX,
        PTR_LO,
        PTR_HI,
        FIXUP,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        mode_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] ptr_q;
    logic [DATA_W-1:0] ptr_nx;
    logic [DATA_W-1:0] idx_sel;
    logic [SUM_W-1:0]  idx_sum;
    logic              idx_carry;

    // X indexes ZPX/ABSX; every other indexed mode uses Y.
    assign idx_sel   = ((mode_q == M_ZPX) || (mode_q == M_ABSX)) ? idx_x : idx_y;
    assign idx_sum   = SUM_W'(lo_q) + SUM_W'(idx_sel);
    assign idx_carry = idx_sum[DATA_W];
    assign ptr_nx    = ptr_q + DATA_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bus-cycle outputs, decoded from the current state.
    always_comb begin
        state_d = state_q;
        addr    = pc_in;
        pc_inc  = 1'b0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH_LO;
                end
            end
            FETCH_LO: begin
                pc_inc = 1'b1;
                case (mode_q)
                    M_IMM, M_ZP:   state_d = DONE;
                    M_ZPX, M_ZPY:  state_d = INDEX;
                    M_INDY:        state_d = PTR_LO;
                    default:       state_d = FETCH_HI;
                endcase
            end
            FETCH_HI: begin
                pc_inc = 1'b1;
                if ((mode_q != M_ABS) && idx_carry) begin
                    state_d = FIXUP;
                end else begin
                    state_d = DONE;
                end
            end
            INDEX: begin
                state_d = DONE;
            end
            PTR_LO: begin
                addr    = ADDR_W'(ptr_q);
                state_d = PTR_HI;
            end
            PTR_HI: begin
                // Pointer high byte wraps inside page 0.
                addr    = ADDR_W'(ptr_nx);
                state_d = idx_carry ? FIXUP : DONE;
            end
            FIXUP: begin
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand/pointer capture and effective-address formation.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= M_ZPX;
            lo_q       <= '0;
            ptr_q      <= '0;
            ea         <= '0;
            page_cross <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        page_cross <= 1'b0;
                    end
                end
                FETCH_LO: begin
                    case (mode_q)
                        M_IMM:   ea    <= pc_in;
                        M_ZP:    ea    <= ADDR_W'(d_in);
                        M_INDY:  ptr_q <= d_in;
                        default: lo_q  <= d_in;
                    endcase
                end
                INDEX: begin
                    if (ZP_WRAP) begin
                        ea <= ADDR_W'(idx_sum[DATA_W-1:0]);
                    end else begin
                        ea <= ADDR_W'(idx_sum);
                    end
                end
                FETCH_HI: begin
                    if (mode_q == M_ABS) begin
                        ea <= {HI_W'(d_in), lo_q};
                    end else begin
                        ea <= {HI_W'(d_in), idx_sum[DATA_W-1:0]};
                    end
                end
                PTR_LO: begin
                    lo_q <= d_in;
                end
                PTR_HI: begin
                    ea <= {HI_W'(d_in), idx_sum[DATA_W-1:0]};
                end
                FIXUP: begin
                    ea[ADDR_W-1:DATA_W] <= ea[ADDR_W-1:DATA_W] + HI_W'(1);
                    page_cross          <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/addr_gen.md
Name: addr_gen

Overview:
Parametrised operand-fetch and effective-address sequencer for the CPU core. It sits between the program counter, the index registers and the byte-wide memory bus. On a start pulse it fetches operand bytes at the PC and, for indirect modes, fetches pointer bytes. It computes the effective address with index addition, zero-page wrap and page-cross fix-up, then presents the result to the ALU/load-store path.

Parameters:
DATA_W, 8, data bus and index register width in bits
ADDR_W, 16, address width in bits; must equal 2*DATA_W
ZP_WRAP, 1, 1 = zero-page indexed results wrap within page 0; 0 = carry propagates into the high byte

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin address sequence; sampled only in IDLE
mode  in  3  addressing mode, latched on accepted start
idx_x  in  DATA_W  X index register, sampled during the indexing cycle
idx_y  in  DATA_W  Y index register, sampled during the indexing cycle
pc_in  in  ADDR_W  current program counter
d_in  in  DATA_W  read data; valid in the same cycle addr is driven (combinational read)
addr  out  ADDR_W  bus address for the current cycle
pc_inc  out  1  one operand byte consumed this cycle; PC owner increments on the next edge
busy  out  1  state != IDLE
done  out  1  one-cycle pulse; ea valid
ea  out  ADDR_W  effective address; held until the next accepted start
page_cross  out  1  set with done when index addition carried out of the low byte; held with ea

Behaviour:
- Mode codes:
  - ZPX=000, ZP=001, IMM=010, ABS=011, ZPY=100, ABSX=101, ABSY=110, INDY=111 ((zp),Y).
- States:
  - IDLE, FETCH_LO, FETCH_HI, INDEX, PTR_LO, PTR_HI, FIXUP, DONE.
- Reset:
  - state=IDLE; ea=0, page_cross=0, done=0, pc_inc=0, busy=0.
  - addr=pc_in in IDLE.
  - rst asserted mid-sequence returns to IDLE on that edge, with no done and no further pc_inc.
- Start handling:
  - IDLE + start: latch mode, go to FETCH_LO (cycle 1).
  - start while busy is ignored.
- FETCH_LO:
  - addr=pc_in, pc_inc=1.
  - IMM: ea=pc_in.
  - Otherwise capture d_in as the low byte (or as the pointer for INDY).
  - Next state: IMM/ZP to DONE; ZPX/ZPY to INDEX; ABS* to FETCH_HI; INDY to PTR_LO.
- INDEX (ZPX/ZPY):
  - With ZP_WRAP=1: ea={0, (lo+idx) mod 2^DATA_W}.
  - With ZP_WRAP=0: ea=lo+idx, zero-extended.
  - page_cross=0.
  - Next state: DONE.
- FETCH_HI:
  - addr=pc_in, pc_inc=1, hi=d_in.
  - ABS: ea={hi, lo}, then DONE.
  - ABSX/ABSY: sum=lo+idx (DATA_W+1 bits), ea={hi, sum[DATA_W-1:0]}.
  - If the carry is set: go to FIXUP; otherwise go to DONE.
- PTR_LO:
  - addr={0, ptr}; capture lo=d_in.
  - No pc_inc.
- PTR_HI:
  - addr={0, (ptr+1) mod 2^DATA_W}, so the pointer wraps within page 0.
  - hi=d_in.
  - Add Y to the low byte exactly as in ABSY; carry goes to FIXUP, otherwise to DONE.
- FIXUP:
  - ea high byte += 1, modulo 2^DATA_W, so 0xFF wraps to 0x00.
  - page_cross=1.
  - Next state: DONE.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Next state: IDLE.
  - A start in the DONE cycle is ignored.
- addr outside PTR states = pc_in.
- pc_inc total per sequence:
  - IMM/ZP/ZPX/ZPY/INDY: 1.
  - ABS/ABSX/ABSY: 2.
- Latency (start at cycle 0; done at cycle N):
  - IMM/ZP: 2.
  - ZPX/ZPY: 3.
  - ABS: 3.
  - ABSX/ABSY: 3 without cross, 4 with cross.
  - INDY: 4 without cross, 5 with cross.
- page_cross is cleared on accepted start and held with ea after done.

Test Plan:
- ZP, d_in@FETCH_LO=0x44, pc_in=0x8001 -> addr=0x8001, pc_inc=1 at cycle 1; done at cycle 2; ea=0x0044; page_cross=0.
- ZPX, operand 0xF0, idx_x=0x20, ZP_WRAP=1 -> ea=0x0010 at cycle 3. Same with ZP_WRAP=0 -> ea=0x0110.
- ABSX:
  - operand bytes 0x34, 0x12, idx_x=0x05 -> ea=0x1239, done at cycle 3, page_cross=0, two pc_inc pulses.
  - operands 0xFF, 0x12, idx_x=0x01 -> ea=0x1300, done at cycle 4, page_cross=1.
- INDY:
  - ptr=0x86, mem[0x0086]=0x28, mem[0x0087]=0x40, idx_y=0x10 -> addr sequence pc, 0x0086, 0x0087; ea=0x4038; done at cycle 4.
  - ptr=0xFF -> reads 0x00FF then 0x0000.
  - {hi=0xFF, lo=0xF0}+Y=0x20 -> ea=0x0010, page_cross=1, done at cycle 5.
- ABS with start re-pulsed at cycles 1 and 3 -> ignored; exactly one done; ea unchanged until the next IDLE start.
- ABSY, rst asserted at cycle 2 -> IDLE at cycle 3, busy=0, no done, ea=0, page_cross=0. A fresh start afterwards completes normally.
